// File: rtl/branching_buffer.sv
// Direct-mapped 1024-entry branch target buffer with four local
// 2-bit saturating predictors per entry; reads are combinational.
module branching_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCTargetE,
    input  logic [9:0]  PCF,
    input  logic [9:0]  PCE,
    input  logic [1:0]  LocalSrc,
    input  logic        PCSrcResE,
    input  logic        TargetMatch,
    input  logic [1:0]  BranchOpE,
    output logic        PCSrcPredF,
    output logic [31:0] PredPCTargetF
);

    typedef enum logic [1:0] {
        SU = 2'b00,
        WU = 2'b01,
        WT = 2'b10,
        ST = 2'b11
    } ctr_e;

    logic [31:0] target_q [1024];
    logic [1:0]  pred_q   [1024][4];

    logic [1:0]  ctr_q;
    logic [1:0]  ctr_d;
    logic        upd_en;
    logic        unused_branchop;

    assign unused_branchop = BranchOpE[1];
    assign upd_en          = BranchOpE[0];

    assign PredPCTargetF = target_q[PCF];
    assign PCSrcPredF    = pred_q[PCF][LocalSrc][1];

    // Saturating counter step for the selected predictor of entry PCE
    assign ctr_q = pred_q[PCE][LocalSrc];

    always_comb begin
        ctr_d = ctr_q;
        if (PCSrcResE) begin
            if (ctr_q != ST) ctr_d = ctr_q + 2'd1;
        end else begin
            if (ctr_q != SU) ctr_d = ctr_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
                target_q[i] <= '0;
                for (int k = 0; k < 4; k++) begin
                    pred_q[i][k] <= WU;
                end
            end
        end else if (upd_en) begin
            if (!TargetMatch) begin
                // New target: forget all history for this entry
                target_q[PCE] <= PCTargetE;
                for (int k = 0; k < 4; k++) begin
                    pred_q[PCE][k] <= WU;
                end
            end else begin
                pred_q[PCE][LocalSrc] <= ctr_d;
            end
        end
    end

endmodule

// File: tb/tb_branching_buffer.sv
// Scoreboard bench for branching_buffer: a reference model plus
// fixed expectations feed a queue that is drained on each read.
module tb_branching_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCTargetE;
    logic [9:0]  PCF;
    logic [9:0]  PCE;
    logic [1:0]  LocalSrc;
    logic        PCSrcResE;
    logic        TargetMatch;
    logic [1:0]  BranchOpE;
    logic        PCSrcPredF;
    logic [31:0] PredPCTargetF;

    logic [31:0] m_tgt  [1024];
    logic [1:0]  m_pred [1024][4];
    logic [32:0] sb_q [$];

    int n_chk  = 0;
    int n_fail = 0;

    branching_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .PCTargetE    (PCTargetE),
        .PCF          (PCF),
        .PCE          (PCE),
        .LocalSrc     (LocalSrc),
        .PCSrcResE    (PCSrcResE),
        .TargetMatch  (TargetMatch),
        .BranchOpE    (BranchOpE),
        .PCSrcPredF   (PCSrcPredF),
        .PredPCTargetF(PredPCTargetF)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] got,
                         input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got pred=%0b tgt=%h exp pred=%0b tgt=%h",
                     tag, got[32], got[31:0], exp[32], exp[31:0]);
        end
    endtask

    // Reference model of one clock edge, using the currently driven inputs
    task automatic model_edge();
        logic [1:0] c;
        if (reset) begin
            for (int i = 0; i < 1024; i++) begin
                m_tgt[i] = '0;
                for (int k = 0; k < 4; k++) m_pred[i][k] = 2'b01;
            end
        end else if (BranchOpE[0]) begin
            if (!TargetMatch) begin
                m_tgt[PCE] = PCTargetE;
                for (int k = 0; k < 4; k++) m_pred[PCE][k] = 2'b01;
            end else begin
                c = m_pred[PCE][LocalSrc];
                case (c)
                    2'b00: c = PCSrcResE ? 2'b01 : 2'b00;
                    2'b01: c = PCSrcResE ? 2'b10 : 2'b00;
                    2'b10: c = PCSrcResE ? 2'b11 : 2'b01;
                    default: c = PCSrcResE ? 2'b11 : 2'b10;
                endcase
                m_pred[PCE][LocalSrc] = c;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input int pce, input logic [31:0] tgt,
                       input logic tm, input logic res,
                       input logic [1:0] op, input logic [1:0] ls);
        PCE         = 10'(pce);
        PCTargetE   = tgt;
        TargetMatch = tm;
        PCSrcResE   = res;
        BranchOpE   = op;
        LocalSrc    = ls;
        tick();
        BranchOpE   = 2'b00;
    endtask

    // Read checked against the reference model
    task automatic rd(input int pcf, input logic [1:0] ls, input string tag);
        logic [32:0] exp;
        PCF      = 10'(pcf);
        LocalSrc = ls;
        sb_q.push_back({m_pred[pcf][ls][1], m_tgt[pcf]});
        #1;
        exp = sb_q.pop_front();
        check(tag, {PCSrcPredF, PredPCTargetF}, exp);
    endtask

    // Read checked against a fixed expectation
    task automatic rdk(input int pcf, input logic [1:0] ls, input logic p,
                       input logic [31:0] t, input string tag);
        logic [32:0] exp;
        PCF      = 10'(pcf);
        LocalSrc = ls;
        sb_q.push_back({p, t});
        #1;
        exp = sb_q.pop_front();
        check(tag, {PCSrcPredF, PredPCTargetF}, exp);
    endtask

    initial begin
        reset = 1'b1; PCTargetE = '0; PCF = '0; PCE = '0; LocalSrc = '0;
        PCSrcResE = 1'b0; TargetMatch = 1'b0; BranchOpE = 2'b00;
        @(negedge clk);
        tick();
        reset = 1'b0;
        rdk(5, 2'd0, 1'b0, 32'd0, "reset_e5");
        rdk(1023, 2'd3, 1'b0, 32'd0, "reset_e1023");

        for (int i = 0; i < 1024; i++) upd(i, 32'(i), 1'b0, 1'b0, 2'b01, 2'd0);
        for (int i = 0; i < 1024; i++) rdk(i, 2'(i), 1'b0, 32'(i), "populate");

        upd(0, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b1, 32'd0, "ctr_wu_t");
        upd(0, 32'd0, 1'b1, 1'b0, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b0, 32'd0, "ctr_wt_nt");
        repeat (2) upd(0, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b1, 32'd0, "ctr_st");
        repeat (4) begin
            upd(0, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
            rd(0, 2'd0, "ctr_sat_t");
        end
        upd(0, 32'd0, 1'b1, 1'b0, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b1, 32'd0, "ctr_st_hold");
        repeat (4) begin
            upd(0, 32'd0, 1'b1, 1'b0, 2'b01, 2'd0);
            rd(0, 2'd0, "ctr_sat_nt");
        end
        upd(0, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b0, 32'd0, "ctr_su_hold");
        repeat (3) upd(0, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b1, 32'd0, "ctr_st_again");

        repeat (2) upd(1, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
        upd(0, 32'd1000, 1'b0, 1'b0, 2'b01, 2'd0);
        rdk(0, 2'd0, 1'b0, 32'd1000, "replace_e0");
        rd(0, 2'd3, "replace_e0_ls3");
        rdk(1, 2'd0, 1'b1, 32'd1, "replace_e1_kept");

        upd(100, 32'd1001, 1'b0, 1'b1, 2'b01, 2'd0);
        repeat (2) upd(100, 32'd0, 1'b1, 1'b1, 2'b01, 2'd1);
        rdk(100, 2'd1, 1'b1, 32'd1001, "ls_e100_ls1");
        upd(100, 32'd0, 1'b1, 1'b0, 2'b01, 2'd0);
        rdk(100, 2'd0, 1'b0, 32'd1001, "ls_e100_ls0_nt");
        rd(100, 2'd1, "ls_e100_ls1_kept");
        repeat (2) upd(100, 32'd0, 1'b1, 1'b1, 2'b01, 2'd0);
        rdk(100, 2'd0, 1'b1, 32'd1001, "ls_e100_ls0_t");
        rdk(1, 2'd1, 1'b0, 32'd1, "ls_e1_ls1");

        PCE = 10'd200; PCTargetE = 32'd0; TargetMatch = 1'b1;
        PCSrcResE = 1'b1; BranchOpE = 2'b01; LocalSrc = 2'd2;
        rdk(200, 2'd2, 1'b0, 32'd200, "rbw_pre");
        tick();
        BranchOpE = 2'b00;
        rdk(200, 2'd2, 1'b1, 32'd200, "rbw_post");

        upd(300, 32'hDEADBEEF, 1'b0, 1'b0, 2'b10, 2'd0);
        upd(0, 32'hDEADBEEF, 1'b0, 1'b0, 2'b00, 2'd0);
        upd(100, 32'hDEADBEEF, 1'b1, 1'b0, 2'b10, 2'd1);
        rdk(300, 2'd0, 1'b0, 32'd300, "gate_e300");
        rdk(0, 2'd0, 1'b0, 32'd1000, "gate_e0");
        rdk(100, 2'd1, 1'b1, 32'd1001, "gate_e100");

        reset = 1'b1;
        upd(7, 32'd55, 1'b0, 1'b0, 2'b01, 2'd0);
        reset = 1'b0;
        rdk(7, 2'd0, 1'b0, 32'd0, "rst2_e7");
        rdk(1, 2'd0, 1'b0, 32'd0, "rst2_e1");
        rdk(100, 2'd1, 1'b0, 32'd0, "rst2_e100");
        rdk(1023, 2'd2, 1'b0, 32'd0, "rst2_e1023");
        for (int i = 0; i < 1024; i += 37) rd(i, 2'(i), "rst2_sweep");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
